axis_frame_arbiter: RTL

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

---
 rtl/axis_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/axis_frame_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared FSM state type and tid width helper for the frame arbiter
package axis_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int tidw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after last_grant
module rr_arbiter
    import axis_pkg::*;
#(
    parameter  int NPORTS = 4,
    localparam int TIDW   = tidw(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [TIDW-1:0]   last_grant,
    output logic [NPORTS-1:0] grant,
    output logic              valid
);

    logic [TIDW:0] idx;

    // Walk the ports in priority order (last_grant+1 .. last_grant) and keep the first hit.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = {1'b0, last_grant} + (TIDW+1)'(i);
            if (idx >= (TIDW+1)'(NPORTS)) begin
                idx = idx - (TIDW+1)'(NPORTS);
            end
            if (!valid && req[idx[TIDW-1:0]]) begin
                grant[idx[TIDW-1:0]] = 1'b1;
                valid                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin arbiter over fwft streams with orphan discard
module axis_frame_arbiter
    import axis_pkg::*;
#(
    parameter  int N            = 8,
    parameter  int NPORTS       = 4,
    parameter  int IDLE_TIMEOUT = 16,
    localparam int TIDW         = tidw(NPORTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORTS-1:0]   s_axis_tvalid,
    input  logic [NPORTS-1:0]   s_axis_tfirst,
    input  logic [NPORTS*N-1:0] s_axis_tdata,
    output logic [NPORTS-1:0]   s_axis_tnext,
    output logic                m_axis_tvalid,
    output logic                m_axis_tfirst,
    output logic [N-1:0]        m_axis_tdata,
    output logic [TIDW-1:0]     m_axis_tid,
    input  logic                m_axis_tnext,
    output logic [15:0]         orphan_cnt
);

    arb_state_t        state, state_nxt;
    logic [TIDW-1:0]   g, last_grant, sel_idx;
    logic              started;
    logic [15:0]       starve_cnt;
    logic [NPORTS-1:0] eligible, orphans, sel_onehot;
    logic              sel_valid;
    logic              g_valid, g_first, end_cond, starved, timeout_hit, xfer;
    logic [4:0]        orphan_pop;
    logic [16:0]       orphan_sum;

    assign eligible = s_axis_tvalid & s_axis_tfirst;
    assign orphans  = s_axis_tvalid & ~s_axis_tfirst;

    rr_arbiter #(.NPORTS(NPORTS)) u_rr (
        .req        (eligible),
        .last_grant (last_grant),
        .grant      (sel_onehot),
        .valid      (sel_valid)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = TIDW'(i);
            end
        end
    end

    assign g_valid  = s_axis_tvalid[g];
    assign g_first  = s_axis_tfirst[g];
    // A fresh tfirst after the frame has started is the next frame: stop without consuming it.
    assign end_cond = started & g_valid & g_first;
    assign starved  = ~g_valid;
    assign timeout_hit = (IDLE_TIMEOUT > 0) && starved &&
                         (({16'd0, starve_cnt} + 32'd1) >= 32'(IDLE_TIMEOUT));
    assign xfer     = (state == ST_GRANT) && g_valid && !end_cond && m_axis_tnext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (sel_valid) state_nxt = ST_GRANT;
            ST_GRANT: if (end_cond || timeout_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tfirst = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tid    = '0;
        s_axis_tnext  = '0;
        if (!rst) begin
            case (state)
                ST_IDLE: s_axis_tnext = orphans;
                ST_GRANT: begin
                    m_axis_tdata    = s_axis_tdata[int'(g)*N +: N];
                    m_axis_tfirst   = g_first;
                    m_axis_tid      = g;
                    m_axis_tvalid   = g_valid & ~end_cond;
                    s_axis_tnext[g] = m_axis_tnext & g_valid & ~end_cond;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= TIDW'(NPORTS-1);
            g          <= '0;
            started    <= 1'b0;
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (sel_valid) g <= sel_idx;
            started    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (xfer) begin
                started    <= 1'b1;
                starve_cnt <= '0;
            end else if (starved && starve_cnt != 16'hFFFF) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
            if (end_cond || timeout_hit) begin
                last_grant <= g;
                started    <= 1'b0;
                starve_cnt <= '0;
            end
        end
    end

    always_comb begin
        orphan_pop = '0;
        for (int i = 0; i < NPORTS; i++) begin
            orphan_pop = orphan_pop + 5'(orphans[i]);
        end
        orphan_sum = {1'b0, orphan_cnt} + 17'(orphan_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_cnt <= '0;
        end else if (state == ST_IDLE) begin
            orphan_cnt <= orphan_sum[16] ? 16'hFFFF : orphan_sum[15:0];
        end
    end

endmodule
